// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: FSM state encoding, HALT opcode, MIPS instruction field slices.
package pipeline_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10,
        ST_HALT = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        PC_HOLD   = 2'b00,
        PC_INC    = 2'b01,
        PC_TARGET = 2'b10,
        PC_RESET  = 2'b11
    } pc_sel_e;

    localparam logic [5:0] HALT_OPCODE = 6'b111111;

    localparam int OPC_HI   = 31;
    localparam int OPC_LO   = 26;
    localparam int RS_HI    = 25;
    localparam int RS_LO    = 21;
    localparam int RT_HI    = 20;
    localparam int RT_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 11;
    localparam int SHAMT_HI = 10;
    localparam int SHAMT_LO = 6;
    localparam int FUNCT_HI = 5;
    localparam int FUNCT_LO = 0;

    function automatic logic [5:0] opcode_of(input logic [31:0] instr);
        return instr[OPC_HI:OPC_LO];
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction memory port: the sequencer (master) drives address/write, memory (slave) returns
// combinational read data for the presented address.
interface fetch_sequencer_if #(
    parameter int PC_W = 32
);
    logic [PC_W-1:0] addr;
    logic            we;
    logic [31:0]     wdata;
    logic [31:0]     rdata;

    modport master (output addr, output we, output wdata, input rdata);
    modport slave  (input addr, input we, input wdata, output rdata);
endinterface

// File: rtl/fetch_sequencer_pc_reg.sv
// Word-addressed PC register with next-PC select (hold / +1 / redirect target / RESET_PC).
// Single-cycle update; holding is the default so the caller only asserts a select when PC moves.
module pc_reg
    import pipeline_pkg::*;
#(
    parameter int PC_W     = 32,
    parameter int RESET_PC = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  pc_sel_e         sel_i,
    input  logic [PC_W-1:0] target_i,
    output logic [PC_W-1:0] pc_o
);
    logic [PC_W-1:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        unique case (sel_i)
            PC_HOLD:   pc_d = pc_q;
            PC_INC:    pc_d = pc_q + PC_W'(1);
            PC_TARGET: pc_d = target_i;
            PC_RESET:  pc_d = PC_W'(RESET_PC);
            default:   pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_q <= PC_W'(RESET_PC);
        else        pc_q <= pc_d;
    end

    assign pc_o = pc_q;
endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: IDLE/LOAD/RUN/HALT FSM, IF/ID register, imem port arbitration.
// IF/ID output appears one cycle after PC presents the address; stall holds PC and IF/ID.
module fetch_sequencer #(
    parameter int         PC_W        = 32,
    parameter int         MEM_DEPTH   = 32,
    parameter int         LOAD_AW     = 5,
    parameter int         RESET_PC    = 0,
    parameter logic [5:0] HALT_OPCODE = pipeline_pkg::HALT_OPCODE
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic               i_load_en,
    input  logic               i_load_valid,
    input  logic [LOAD_AW-1:0] i_load_addr,
    input  logic [31:0]        i_load_data,
    input  logic               i_stall,
    input  logic               i_branch_taken,
    input  logic [PC_W-1:0]    i_branch_target,
    fetch_sequencer_if.master  imem,
    output logic [31:0]        o_if_instr,
    output logic [PC_W-1:0]    o_if_pc1,
    output logic               o_if_valid,
    output logic [1:0]         o_state,
    output logic               o_pc_fault,
    output logic [31:0]        o_fetch_count
);
    import pipeline_pkg::*;

    state_e          state_q, state_d;
    logic [31:0]     instr_q, instr_d;
    logic [PC_W-1:0] pc1_q, pc1_d;
    logic            valid_q, valid_d;
    logic            fault_q, fault_d;
    logic [31:0]     count_q, count_d;
    pc_sel_e         pc_sel;
    logic [PC_W-1:0] pc;
    logic            pc_oor;

    pc_reg #(.PC_W(PC_W), .RESET_PC(RESET_PC)) u_pc (
        .clk      (clk),
        .rst_n    (rst_n),
        .sel_i    (pc_sel),
        .target_i (i_branch_target),
        .pc_o     (pc)
    );

    // Widen by one bit so MEM_DEPTH == 2^PC_W still compares correctly.
    assign pc_oor = ({1'b0, pc} >= (PC_W+1)'(MEM_DEPTH));

    always_comb begin
        if (state_q == ST_LOAD) begin
            imem.addr  = PC_W'(i_load_addr);
            imem.we    = i_load_valid;
            imem.wdata = i_load_data;
        end else begin
            imem.addr  = pc;
            imem.we    = 1'b0;
            imem.wdata = 32'h0;
        end
    end

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        pc1_d   = pc1_q;
        valid_d = valid_q;
        fault_d = fault_q;
        count_d = count_q;
        pc_sel  = PC_HOLD;
        unique case (state_q)
            ST_IDLE, ST_HALT: begin
                valid_d = 1'b0;
                if (i_load_en) begin
                    state_d = ST_LOAD;
                end else if (i_start) begin
                    state_d = ST_RUN;
                    pc_sel  = PC_RESET;
                    count_d = 32'h0;
                    fault_d = 1'b0;
                end
            end
            ST_LOAD: begin
                valid_d = 1'b0;
                if (!i_load_en) state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (i_branch_taken) begin
                    pc_sel  = PC_TARGET;
                    valid_d = 1'b0;
                end else if (i_stall) begin
                    pc_sel  = PC_HOLD;
                end else if (pc_oor) begin
                    state_d = ST_HALT;
                    fault_d = 1'b1;
                    valid_d = 1'b0;
                end else if (opcode_of(imem.rdata) == HALT_OPCODE) begin
                    state_d = ST_HALT;
                    valid_d = 1'b0;
                end else begin
                    instr_d = imem.rdata;
                    pc1_d   = pc + PC_W'(1);
                    valid_d = 1'b1;
                    pc_sel  = PC_INC;
                    count_d = (count_q == 32'hFFFF_FFFF) ? count_q : count_q + 32'h1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            instr_q <= 32'h0;
            pc1_q   <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            count_q <= 32'h0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            pc1_q   <= pc1_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
            count_q <= count_d;
        end
    end

    assign o_if_instr    = instr_q;
    assign o_if_pc1      = pc1_q;
    assign o_if_valid    = valid_q;
    assign o_state       = state_q;
    assign o_pc_fault    = fault_q;
    assign o_fetch_count = count_q;
endmodule
